inst_queue_ctrl: RTL and testbench

Dual-port instruction queue controller sitting between the fetch stage and the dual-issue stage. Fetch pushes up to two 99-bit fetch packets per cycle. The issue stage reads the two oldest entries as slot 1 and slot 2 and pops 0, 1 or 2 entries per cycle. A flush from mem (refetch/redirect) empties the queue in one cycle.

---
 rtl/inst_queue_ctrl.sv | 139 +++++++++++++
 tb/tb_inst_queue_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue_ctrl.sv
// -----------------------------------------------------------------------------
// inst_queue_ctrl
//
// Dual-port instruction queue between fetch and the dual-issue stage.
// Fetch pushes up to two packets per cycle; issue sees the two oldest entries
// as slot 1 / slot 2 and pops 0, 1 or 2 of them per cycle. A flush from mem
// (refetch/redirect) empties the queue in a single cycle.
//
// Entry layout (WIDTH = 99):
//   {pred_taken[98], pred_target[97:66], i_refill_tlbl[65],
//    i_invalid_tlbl[64], pc[63:32], inst[31:0]}
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   flush             discard all entries (below rst in priority)
//   w_ena_1/w_data_1  push request / data, older packet
//   w_ena_2/w_data_2  push request / data, younger packet (needs w_ena_1)
//   w_ready           queue can accept two pushes this cycle
//   push_drop         combinational pulse: w_ena_1 while w_ready=0
//   fifo_r_data_1/_ok oldest entry and its valid
//   fifo_r_data_2/_ok second-oldest entry and its valid
//   p_data_1          pop oldest entry
//   p_data_2          pop second entry (needs p_data_1)
//   count             current occupancy
//
// Handshake: a push is accepted on a rising edge when w_ena_1=1 and w_ready=1
// (w_ready depends only on the registered count, never on the same-cycle pop);
// a pop is accepted when p_data_1=1 and fifo_r_data_1_ok=1, and the second pop
// additionally needs p_data_2=1 and fifo_r_data_2_ok=1. Pushes presented while
// w_ready=0 are lost and flagged on push_drop; the producer must replay them.
// -----------------------------------------------------------------------------
module inst_queue_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 99
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       w_ena_1,
    input  logic [WIDTH-1:0]           w_data_1,
    input  logic                       w_ena_2,
    input  logic [WIDTH-1:0]           w_data_2,
    output logic                       w_ready,
    output logic                       push_drop,
    output logic [WIDTH-1:0]           fifo_r_data_1,
    output logic                       fifo_r_data_1_ok,
    output logic [WIDTH-1:0]           fifo_r_data_2,
    output logic                       fifo_r_data_2_ok,
    input  logic                       p_data_1,
    input  logic                       p_data_2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage is deliberately not reset; the ok flags mask stale contents.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic          ok1, ok2;
    logic          pop1, pop2;
    logic          push1, push2;
    logic [CW-1:0] npop, npush;

    // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH for free.
    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    assign ok1 = (count_q != '0);
    assign ok2 = (count_q >= CW'(2));

    // Room for two is required even for a single push, keeping fetch simple.
    assign w_ready   = (count_q <= CW'(DEPTH - 2));
    assign push_drop = w_ena_1 & ~w_ready;

    assign pop1  = p_data_1 & ok1;
    assign pop2  = p_data_1 & p_data_2 & ok2;
    assign push1 = w_ena_1 & w_ready;
    assign push2 = w_ena_1 & w_ena_2 & w_ready;

    assign npop  = CW'(pop1) + CW'(pop2);
    assign npush = CW'(push1) + CW'(push2);

    assign fifo_r_data_1    = ok1 ? mem_q[head_q]  : '0;
    assign fifo_r_data_2    = ok2 ? mem_q[head_p1] : '0;
    assign fifo_r_data_1_ok = ok1;
    assign fifo_r_data_2_ok = ok2;
    assign count            = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(npop);
            tail_d  = tail_q + AW'(npush);
            count_d = count_q + npush - npop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // A flushed or reset cycle must not leave writes behind in storage.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push1) mem_q[tail_q]  <= w_data_1;
            if (push2) mem_q[tail_p1] <= w_data_2;
        end
    end

    // Occupancy must stay within [0, DEPTH]; an unsigned wrap below zero
    // would also show up as a value above DEPTH.
    a_count_max : assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        npop <= count_q);

endmodule

// File: tb/tb_inst_queue_ctrl.sv
module tb_inst_queue_ctrl;

    localparam int DEPTH = 16;
    localparam int WIDTH = 99;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             w_ena_1, w_ena_2;
    logic [WIDTH-1:0] w_data_1, w_data_2;
    logic             w_ready, push_drop;
    logic [WIDTH-1:0] fifo_r_data_1, fifo_r_data_2;
    logic             fifo_r_data_1_ok, fifo_r_data_2_ok;
    logic             p_data_1, p_data_2;
    logic [CW-1:0]    count;

    inst_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .w_ena_1          (w_ena_1),
        .w_data_1         (w_data_1),
        .w_ena_2          (w_ena_2),
        .w_data_2         (w_data_2),
        .w_ready          (w_ready),
        .push_drop        (push_drop),
        .fifo_r_data_1    (fifo_r_data_1),
        .fifo_r_data_1_ok (fifo_r_data_1_ok),
        .fifo_r_data_2    (fifo_r_data_2),
        .fifo_r_data_2_ok (fifo_r_data_2_ok),
        .p_data_1         (p_data_1),
        .p_data_2         (p_data_2),
        .count            (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [CW-1:0]    cnt;
        logic             ok1;
        logic             ok2;
        logic             wr;
        logic             drop;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_q[$];   // reference queue, oldest at index 0
    int               n_cmp = 0;
    int               n_err = 0;
    int unsigned      pc_seq = 32'h1000;

    function automatic logic [WIDTH-1:0] mk(input logic [31:0] pc);
        logic [WIDTH-1:0] v;
        v = {1'($urandom), 32'($urandom), 2'($urandom), pc, 32'($urandom)};
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] nxt();
        pc_seq = pc_seq + 4;
        return mk(pc_seq);
    endfunction

    // ---------------- driver ----------------
    // One cycle: record what the DUT must show this cycle (from the model),
    // drive inputs, then advance the model by the queue rules.
    task automatic cycle(input bit r, input bit f, input bit e1, input bit e2,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit q1, input bit q2);
        exp_t e;
        int   sz;
        int   np;
        @(negedge clk);
        sz     = model_q.size();
        e.cnt  = CW'(sz);
        e.ok1  = (sz >= 1);
        e.ok2  = (sz >= 2);
        e.wr   = ((DEPTH - sz) >= 2);
        e.drop = e1 && !e.wr;
        e.d1   = (sz >= 1) ? model_q[0] : '0;
        e.d2   = (sz >= 2) ? model_q[1] : '0;
        exp_q.push_back(e);

        rst = r; flush = f;
        w_ena_1 = e1; w_ena_2 = e2; w_data_1 = a; w_data_2 = b;
        p_data_1 = q1; p_data_2 = q2;

        if (r || f) begin
            model_q.delete();
        end else begin
            np = 0;
            if (q1 && sz >= 1) np = 1;
            if (q1 && q2 && sz >= 2) np = 2;
            for (int i = 0; i < np; i++) void'(model_q.pop_front());
            if (e1 && e.wr) begin
                model_q.push_back(a);
                if (e2) model_q.push_back(b);
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    task automatic push_one();
        cycle(0, 0, 1, 0, nxt(), '0, 0, 0);
    endtask

    task automatic push_two();
        logic [WIDTH-1:0] a, b;
        a = nxt();
        b = nxt();
        cycle(0, 0, 1, 1, a, b, 0, 0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("count",     WIDTH'(count),            WIDTH'(mon_e.cnt));
                chk("ok1",       WIDTH'(fifo_r_data_1_ok), WIDTH'(mon_e.ok1));
                chk("ok2",       WIDTH'(fifo_r_data_2_ok), WIDTH'(mon_e.ok2));
                chk("w_ready",   WIDTH'(w_ready),          WIDTH'(mon_e.wr));
                chk("push_drop", WIDTH'(push_drop),        WIDTH'(mon_e.drop));
                chk("r_data_1",  fifo_r_data_1,            mon_e.d1);
                chk("r_data_2",  fifo_r_data_2,            mon_e.d2);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int push_pct, pop_pct;
        rst = 1'b1; flush = 1'b0;
        w_ena_1 = 1'b0; w_ena_2 = 1'b0; w_data_1 = '0; w_data_2 = '0;
        p_data_1 = 1'b0; p_data_2 = 1'b0;
        repeat (3) @(posedge clk);

        // reset state
        idle(); idle();

        // A single, then B,C dual; pop both; drain
        push_one(); push_two(); idle();
        cycle(0, 0, 0, 0, '0, '0, 1, 1); idle();
        cycle(0, 0, 0, 0, '0, '0, 1, 0); idle();

        // fill to 15, drop a push, pop one, w_ready returns
        repeat (7) push_two();
        push_one(); idle();
        cycle(0, 0, 1, 1, nxt(), nxt(), 0, 0);
        cycle(0, 0, 0, 0, '0, '0, 1, 0); idle();

        // wrap: bring head/tail to 15, dual push lands in 15 and 0
        cycle(0, 1, 0, 0, '0, '0, 0, 0);
        repeat (15) push_one();
        repeat (15) cycle(0, 0, 0, 0, '0, '0, 1, 0);
        push_two(); idle();
        push_two(); idle();
        cycle(0, 0, 0, 0, '0, '0, 1, 1); idle();

        // count=4: simultaneous dual push and dual pop; then p_data_2 alone
        push_two(); idle();
        cycle(0, 0, 1, 1, nxt(), nxt(), 1, 1); idle();
        cycle(0, 0, 0, 0, '0, '0, 0, 1); idle();

        // flush at count=6 with a dual push, then push X
        push_two(); idle();
        cycle(0, 1, 1, 1, nxt(), nxt(), 1, 1); idle();
        push_one(); idle();

        // rst mid-stream at count=5
        push_two(); push_two(); idle();
        cycle(1, 0, 1, 1, nxt(), nxt(), 1, 1); idle();
        push_one(); idle();

        // random traffic with phases biased toward full / empty
        for (int ph = 0; ph < 12; ph++) begin
            push_pct = $urandom_range(20, 95);
            pop_pct  = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                logic [WIDTH-1:0] a, b;
                a = nxt();
                b = nxt();
                cycle($urandom_range(0, 299) == 0, $urandom_range(0, 99) == 0,
                      $urandom_range(0, 99) < push_pct, $urandom_range(0, 1) == 1,
                      a, b,
                      $urandom_range(0, 99) < pop_pct, $urandom_range(0, 1) == 1);
            end
        end
        idle();

        // let the monitor consume the last expectations
        repeat (3) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
